// File: rtl/nano_boot_loader.sv
// Byte-stream boot loader: parses a framed image, writes IMEM words,
// verifies the XOR checksum and releases the core from reset.
module nano_boot_loader #(
    parameter int NANO_I_W_C     = 12,
    parameter int NANO_I_ADR_W_C = 8
) (
    input  logic                      i_nano_clk,
    input  logic                      i_nano_rst_n,
    input  logic [7:0]                i_byte,
    input  logic                      i_byte_valid,
    output logic                      o_byte_ready,
    output logic                      o_imem_we,
    output logic [NANO_I_ADR_W_C-1:0] o_imem_addr,
    output logic [NANO_I_W_C-1:0]     o_imem_data,
    output logic                      o_boot_done,
    output logic                      o_boot_err,
    output logic                      o_core_rst_n
);

    localparam int BPW   = (NANO_I_W_C + 7) / 8;
    localparam int ASM_W = BPW * 8;
    localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [BC_W-1:0] BC_LAST = BC_W'(BPW - 1);
    localparam logic [16:0]     N_MAX   = 17'(64'd1 << NANO_I_ADR_W_C);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_PAYLOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                      w_ready;
    logic                      w_done;
    logic                      w_err;
    logic                      w_accept;
    logic [15:0]               w_count;
    logic                      w_last_byte;
    logic                      w_last_word;
    logic [ASM_W-1:0]          w_word;

    logic [7:0]                r_cnt_lo;
    logic [15:0]               r_words_left;
    logic [BC_W-1:0]           r_bcnt;
    logic [ASM_W-1:0]          r_asm;
    logic [7:0]                r_xor;
    logic [NANO_I_ADR_W_C-1:0] r_addr;
    logic                      r_we;
    logic [NANO_I_ADR_W_C-1:0] r_imem_addr;
    logic [NANO_I_W_C-1:0]     r_imem_data;
    logic                      r_core_rst_n;

    assign w_accept    = i_byte_valid & w_ready;
    assign w_count     = {i_byte, r_cnt_lo};
    assign w_last_byte = (r_bcnt == BC_LAST);
    assign w_last_word = (r_words_left == 16'd1);

    // Current word with the incoming byte dropped into its lane
    always_comb begin
        w_word = r_asm;
        w_word[8*int'(r_bcnt) +: 8] = i_byte;
    end

    // State register; core reset release tracks entry into DONE
    always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
        if (!i_nano_rst_n) begin
            r_state      <= S_HDR_LO;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_core_rst_n <= (w_next == S_DONE);
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HDR_LO: begin
                if (w_accept) w_next = S_HDR_HI;
            end
            S_HDR_HI: begin
                if (w_accept) begin
                    if ({1'b0, w_count} > N_MAX) w_next = S_ERR;
                    else if (w_count == 16'd0)   w_next = S_CHECK;
                    else                         w_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (w_accept && w_last_byte && w_last_word)
                    w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_accept)
                    w_next = (i_byte == r_xor) ? S_DONE : S_ERR;
            end
            S_DONE:  w_next = S_DONE;
            S_ERR:   w_next = S_ERR;
            default: w_next = S_ERR;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        w_done  = 1'b0;
        w_err   = 1'b0;
        unique case (r_state)
            S_HDR_LO,
            S_HDR_HI,
            S_PAYLOAD,
            S_CHECK:  w_ready = 1'b1;
            S_DONE:   w_done  = 1'b1;
            S_ERR:    w_err   = 1'b1;
            default:  w_err   = 1'b1;
        endcase
    end

    always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
        if (!i_nano_rst_n) begin
            r_cnt_lo     <= '0;
            r_words_left <= '0;
            r_bcnt       <= '0;
            r_asm        <= '0;
            r_xor        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_imem_addr  <= '0;
            r_imem_data  <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_accept) begin
                case (r_state)
                    S_HDR_LO: begin
                        r_cnt_lo <= i_byte;
                        r_xor    <= r_xor ^ i_byte;
                    end
                    S_HDR_HI: begin
                        r_words_left <= w_count;
                        r_xor        <= r_xor ^ i_byte;
                    end
                    S_PAYLOAD: begin
                        r_xor <= r_xor ^ i_byte;
                        r_asm <= w_word;
                        if (w_last_byte) begin
                            r_bcnt       <= '0;
                            r_we         <= 1'b1;
                            r_imem_addr  <= r_addr;
                            r_imem_data  <= w_word[NANO_I_W_C-1:0];
                            r_addr       <= r_addr + 1'b1;
                            r_words_left <= r_words_left - 16'd1;
                        end else begin
                            r_bcnt <= r_bcnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_byte_ready = w_ready;
    assign o_imem_we    = r_we;
    assign o_imem_addr  = r_imem_addr;
    assign o_imem_data  = r_imem_data;
    assign o_boot_done  = w_done;
    assign o_boot_err   = w_err;
    assign o_core_rst_n = r_core_rst_n;

endmodule

// File: tb/tb_nano_boot_loader.sv
// Table-driven bench for nano_boot_loader with an IMEM write scoreboard.
module tb_nano_boot_loader;

    localparam int W = 12;
    localparam int A = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   byte_i = 8'h00;
    logic         valid = 1'b0;
    logic         ready;
    logic         we;
    logic [A-1:0] addr;
    logic [W-1:0] data;
    logic         done;
    logic         err;
    logic         core_rst_n;

    always #5 clk = ~clk;

    nano_boot_loader #(
        .NANO_I_W_C     (W),
        .NANO_I_ADR_W_C (A)
    ) dut (
        .i_nano_clk   (clk),
        .i_nano_rst_n (rst_n),
        .i_byte       (byte_i),
        .i_byte_valid (valid),
        .o_byte_ready (ready),
        .o_imem_we    (we),
        .o_imem_addr  (addr),
        .o_imem_data  (data),
        .o_boot_done  (done),
        .o_boot_err   (err),
        .o_core_rst_n (core_rst_n)
    );

    typedef struct {
        string      name;
        int         len;
        logic [7:0] b [36];
        int         gap;
        bit         done;
        bit         err;
    } vec_t;

    typedef struct packed {
        logic [A-1:0] a;
        logic [W-1:0] d;
    } wr_t;

    vec_t vt [6];
    wr_t  exp_q [$];
    wr_t  wlog [$];
    int   n_vec = 0;
    int   n_miss = 0;
    logic prev_we = 1'b0;

    task automatic chk(input string nm, input int unsigned act,
                       input int unsigned exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every strobe
    always @(negedge clk) begin : mon
        wr_t e;
        if (we) begin
            wlog.push_back('{a: addr, d: data});
            n_vec++;
            if (exp_q.size() == 0) begin
                n_miss++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected",
                         addr, data);
            end else begin
                e = exp_q.pop_front();
                if ({addr, data} !== e) begin
                    n_miss++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h expected addr 0x%0h data 0x%0h",
                             addr, data, e.a, e.d);
                end
            end
            if (prev_we) begin
                n_vec++;
                n_miss++;
                $display("FAIL we_pulse: got back-to-back strobe expected single cycle");
            end
        end
        prev_we = we;
    end

    task automatic put(input logic [7:0] b);
        @(negedge clk);
        byte_i = b;
        valid  = 1'b1;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        byte_i = 8'($urandom);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, ready, 1);
        chk({tag, "_we"},    we, 0);
        chk({tag, "_addr"},  addr, 0);
        chk({tag, "_data"},  data, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   err, 0);
        chk({tag, "_core"},  core_rst_n, 0);
    endtask

    task automatic chk_normal_log(input string tag);
        chk({tag, "_nwr"}, wlog.size(), 3);
        if (wlog.size() >= 3) begin
            chk({tag, "_w0"}, wlog[0], {4'h0, 12'h234});
            chk({tag, "_w1"}, wlog[1], {4'h1, 12'hBCD});
            chk({tag, "_w2"}, wlog[2], {4'h2, 12'h00F});
        end
    endtask

    task automatic fill(input int k, input string nm, input logic [7:0] bs [$],
                        input int gap, input bit dn, input bit er);
        vt[k].name = nm;
        vt[k].len  = bs.size();
        vt[k].gap  = gap;
        vt[k].done = dn;
        vt[k].err  = er;
        foreach (bs[i]) vt[k].b[i] = bs[i];
    endtask

    task automatic run_frame(input int k, input bit do_rst);
        int  n;
        bit  ok_hdr;
        bit  any;
        wr_t last;
        string nm;
        nm  = vt[k].name;
        any = 1'b0;
        last = '0;
        if (do_rst) begin
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            chk_reset({nm, "_rst"});
            rst_n = 1'b1;
        end
        wlog.delete();
        n = {vt[k].b[1], vt[k].b[0]};
        ok_hdr = (n <= 16);
        for (int i = 0; i < vt[k].len; i++) begin
            if (i > 0) repeat (vt[k].gap) @(posedge clk);
            if (i == vt[k].len - 1)
                chk({nm, "_pre_final"}, {done, err, core_rst_n}, 0);
            if (ok_hdr && i >= 3 && i < 2 + 2 * n && (i % 2) == 1) begin
                last = '{a: A'((i - 3) / 2),
                         d: {vt[k].b[i][3:0], vt[k].b[i-1]}};
                exp_q.push_back(last);
                any = 1'b1;
            end
            put(vt[k].b[i]);
        end
        @(negedge clk);
        chk({nm, "_done"},  done, vt[k].done);
        chk({nm, "_err"},   err, vt[k].err);
        chk({nm, "_core"},  core_rst_n, vt[k].done);
        chk({nm, "_ready"}, ready, 0);
        repeat (3) put(8'($urandom));
        @(negedge clk);
        chk({nm, "_hold_st"}, {done, err, ready}, {vt[k].done, vt[k].err, 1'b0});
        chk({nm, "_pending"}, exp_q.size(), 0);
        if (any) chk({nm, "_hold_wr"}, {addr, data}, last);
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] bs [$];
        logic [7:0] x;

        fill(0, "normal", '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                            8'h0F, 8'h00, 8'h4C}, 0, 1'b1, 1'b0);
        fill(1, "badsum", '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                            8'h0F, 8'h00, 8'h9A}, 0, 1'b0, 1'b1);
        fill(2, "empty", '{8'h00, 8'h00, 8'h00}, 0, 1'b1, 1'b0);
        fill(3, "oversize", '{8'h11, 8'h00}, 0, 1'b0, 1'b1);
        fill(4, "gapped", '{8'h03, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB,
                            8'h0F, 8'h00, 8'h4C}, 5, 1'b1, 1'b0);
        bs = '{8'h10, 8'h00};
        for (int w = 0; w < 16; w++) begin
            bs.push_back(8'(w * 16 + 5));
            bs.push_back(8'(8'hA0 | w));
        end
        x = 8'h00;
        foreach (bs[i]) x ^= bs[i];
        bs.push_back(x);
        fill(5, "full16", bs, 0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            run_frame(k, 1'b1);
            if (k == 0) chk_normal_log("normal");
            if (k == 1) chk_normal_log("badsum");
            if (k == 4) chk_normal_log("gapped");
        end

        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        put(8'h03);
        put(8'h00);
        put(8'h34);
        put(8'h12);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("midload");
        chk("midload_pending", exp_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(0, 1'b0);
        chk_normal_log("reload");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
